// File: rtl/fetch_queue.sv
// Fetch queue: 4-entry circular buffer between a 2-wide fetch stage and decode (pops 0-2 per cycle).
// Optional macro FQ_PERF_EN adds o_StallCnt, a saturating count of fetch cycles refused by a full queue.
`ifndef D_WIDTH
`define D_WIDTH 32
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif

module fetch_queue (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_Flush,
    input  logic                i_Valid1F,
    input  logic                i_Valid2F,
    input  logic [`D_WIDTH-1:0] i_Instr1F,
    input  logic [`D_WIDTH-1:0] i_Instr2F,
    input  logic [`D_WIDTH-1:0] i_PC1F,
    input  logic [`D_WIDTH-1:0] i_PC2F,
    output logic                o_Ready,
    input  logic [1:0]          i_Pop,
    output logic                o_Valid1D,
    output logic                o_Valid2D,
    output logic [`D_WIDTH-1:0] o_Instr1D,
    output logic [`D_WIDTH-1:0] o_Instr2D,
    output logic [`D_WIDTH-1:0] o_PC1D,
    output logic [`D_WIDTH-1:0] o_PC2D,
    output logic [2:0]          o_Count
`ifdef FQ_PERF_EN
    ,
    output logic [15:0]         o_StallCnt
`endif
);
    localparam int DW    = `D_WIDTH;
    localparam int DEPTH = `FQ_DEPTH;
    localparam int PW    = $clog2(DEPTH);

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nx1;
    logic [PW-1:0] wr_idx2;
    logic [2:0]    count;
    logic [2:0]    pop_req;
    logic [2:0]    pop_eff;
    logic [2:0]    push_n;

    // Ready looks only at the registered count, so a full queue refuses a push even if decode pops.
    assign o_Ready = (count <= 3'(DEPTH - 2));

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        pop_req  = (i_Pop == 2'd3) ? 3'd2 : {1'b0, i_Pop};
        pop_eff  = (pop_req > count) ? count : pop_req;
        push_n   = o_Ready ? (3'(i_Valid1F) + 3'(i_Valid2F)) : 3'd0;
        // A lone slot-2 instruction lands at the tail; otherwise it follows slot 1.
        wr_idx2  = tail + PW'(i_Valid1F);
        head_nx1 = head + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: storage is reset too, because data outputs must read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_Flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_eff[PW-1:0];
            tail  <= tail + push_n[PW-1:0];
            count <= count - pop_eff + push_n;
            if (o_Ready && i_Valid1F) begin
                mem[tail] <= '{instr: i_Instr1F, pc: i_PC1F};
            end
            if (o_Ready && i_Valid2F) begin
                mem[wr_idx2] <= '{instr: i_Instr2F, pc: i_PC2F};
            end
        end
    end

    assign o_Count   = count;
    assign o_Valid1D = (count >= 3'd1);
    assign o_Valid2D = (count >= 3'd2);
    assign o_Instr1D = mem[head].instr;
    assign o_PC1D    = mem[head].pc;
    assign o_Instr2D = mem[head_nx1].instr;
    assign o_PC2D    = mem[head_nx1].pc;

`ifdef FQ_PERF_EN
    // Survives flushes on purpose: it measures back-pressure across redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_StallCnt <= '0;
        end else if ((i_Valid1F || i_Valid2F) && !o_Ready && (o_StallCnt != 16'hFFFF)) begin
            o_StallCnt <= o_StallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios, then random traffic against a queue model.
// Build with FQ_PERF_EN defined to also check o_StallCnt.
`timescale 1ns/1ps
`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module tb_fetch_queue;
    localparam int DW = `D_WIDTH;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, v1, v2;
    logic [DW-1:0] instr1, instr2, pc1, pc2;
    logic [1:0]    pop;
    logic          ready, valid1, valid2;
    logic [DW-1:0] d_instr1, d_instr2, d_pc1, d_pc2;
    logic [2:0]    count;
`ifdef FQ_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    int unsigned m_stall = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .i_Flush   (flush),
        .i_Valid1F (v1),
        .i_Valid2F (v2),
        .i_Instr1F (instr1),
        .i_Instr2F (instr2),
        .i_PC1F    (pc1),
        .i_PC2F    (pc2),
        .o_Ready   (ready),
        .i_Pop     (pop),
        .o_Valid1D (valid1),
        .o_Valid2D (valid2),
        .o_Instr1D (d_instr1),
        .o_Instr2D (d_instr2),
        .o_PC1D    (d_pc1),
        .o_PC2D    (d_pc2),
        .o_Count   (count)
`ifdef FQ_PERF_EN
        ,
        .o_StallCnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instructions are derived from the PC so directed pushes carry recognisable data.
    task automatic drive(input int a1, input int a2, input int p1, input int p2,
                         input int p, input int f, input int r);
        v1     = (a1 != 0);
        v2     = (a2 != 0);
        pc1    = DW'(p1);
        pc2    = DW'(p2);
        instr1 = DW'(p1) ^ DW'(32'hE3A01001);
        instr2 = DW'(p2) ^ DW'(32'hE2811005);
        pop    = 2'(p);
        flush  = (f != 0);
        rst    = (r != 0);
    endtask

    task automatic compare();
        int n;
        n = mq.size();
        check("count",  64'(count),  64'(n));
        check("ready",  64'(ready),  64'(n <= 2));
        check("valid1", 64'(valid1), 64'(n >= 1));
        check("valid2", 64'(valid2), 64'(n >= 2));
        if (n >= 1) begin
            check("instr1", 64'(d_instr1), 64'(mq[0].instr));
            check("pc1",    64'(d_pc1),    64'(mq[0].pc));
        end
        if (n >= 2) begin
            check("instr2", 64'(d_instr2), 64'(mq[1].instr));
            check("pc2",    64'(d_pc2),    64'(mq[1].pc));
        end
`ifdef FQ_PERF_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    endtask

    // Model step from the current inputs, clock edge, then compare 1ns later.
    task automatic cycle();
        bit can_push;
        int pe;
        can_push = (mq.size() <= 2);
        if (rst) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if ((v1 || v2) && !can_push && m_stall < 65535) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                pe = (pop == 2'd3) ? 2 : int'(pop);
                if (pe > mq.size()) pe = mq.size();
                repeat (pe) void'(mq.pop_front());
                if (can_push && v1) mq.push_back('{instr: instr1, pc: pc1});
                if (can_push && v2) mq.push_back('{instr: instr2, pc: pc2});
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        check("rst_instr1", 64'(d_instr1), 64'(0));
        check("rst_pc1",    64'(d_pc1),    64'(0));
        check("rst_instr2", 64'(d_instr2), 64'(0));
        check("rst_pc2",    64'(d_pc2),    64'(0));

        drive(1, 1, 'h00, 'h04, 0, 0, 0); cycle();
        check("first_count",  64'(count),    64'(2));
        check("first_pc1",    64'(d_pc1),    64'(0));
        check("first_pc2",    64'(d_pc2),    64'('h04));
        check("first_instr1", 64'(d_instr1), 64'(32'hE3A01001));
        check("first_instr2", 64'(d_instr2), 64'(32'hE2811001));

        drive(1, 1, 'h08, 'h0C, 0, 0, 0); cycle();
        check("full_ready", 64'(ready), 64'(0));
        drive(1, 1, 'h10, 'h14, 0, 0, 0); cycle();
        check("full_drop_count", 64'(count), 64'(4));
        drive(0, 0, 0, 0, 2, 0, 0); cycle();
        check("full_pop2_pc1",   64'(d_pc1), 64'('h08));
        check("full_pop2_ready", 64'(ready), 64'(1));

        drive(1, 0, 'h18, 0, 0, 0, 0); cycle();
        drive(1, 1, 'h1C, 'h20, 1, 0, 0); cycle();
        check("c3_reject_count", 64'(count), 64'(2));
        check("c3_reject_pc1",   64'(d_pc1), 64'('h0C));
        drive(1, 1, 'h24, 'h28, 2, 0, 0); cycle();
        check("wrap_count", 64'(count), 64'(2));
        check("wrap_pc1",   64'(d_pc1), 64'('h24));
        check("wrap_pc2",   64'(d_pc2), 64'('h28));

        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 2, 0, 0); cycle();
        check("underflow_count",  64'(count),  64'(0));
        check("underflow_valid1", 64'(valid1), 64'(0));
        drive(0, 1, 0, 'h20, 0, 0, 0); cycle();
        check("slot2_only_pc1",   64'(d_pc1), 64'('h20));
        check("slot2_only_count", 64'(count), 64'(1));

        drive(1, 1, 'h30, 'h34, 0, 0, 0); cycle();
        drive(1, 1, 'h38, 'h3C, 1, 1, 0); cycle();
        check("flush_count",  64'(count),  64'(0));
        check("flush_ready",  64'(ready),  64'(1));
        check("flush_valid1", 64'(valid1), 64'(0));

        drive(1, 1, 'h40, 'h44, 0, 0, 0); cycle();
        drive(1, 1, 'h48, 'h4C, 3, 1, 1); cycle();
        check("midrst_count",  64'(count),    64'(0));
        check("midrst_valid1", 64'(valid1),   64'(0));
        check("midrst_instr1", 64'(d_instr1), 64'(0));
        check("midrst_pc2",    64'(d_pc2),    64'(0));

`ifdef FQ_PERF_EN
        check("stall_after_rst", 64'(stall_cnt), 64'(0));
        drive(1, 1, 'h50, 'h54, 0, 0, 0); cycle();
        drive(1, 1, 'h58, 'h5C, 0, 0, 0); cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 'h60, 'h64, 0, 0, 0); cycle();
        end
        check("stall_five", 64'(stall_cnt), 64'(5));
        drive(0, 0, 0, 0, 0, 1, 0); cycle();
        check("stall_keep_on_flush", 64'(stall_cnt), 64'(5));
        drive(0, 0, 0, 0, 0, 0, 1); cycle();
        check("stall_clear_on_rst", 64'(stall_cnt), 64'(0));
`endif

        for (int n = 0; n < 600; n++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom), int'($urandom),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 24) == 0), int'($urandom_range(0, 149) == 0));
            instr1 = DW'($urandom);
            instr2 = DW'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL use the `D_WIDTH` macro from param.v with default 32; it sets the instruction and PC width.
REQ-002 The block SHALL use `FQ_DEPTH` with default 4; it is the number of queue entries, is fixed, and is not a parameter.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- i_Flush  in  1  discard all entries (branch redirect)
- i_Valid1F, i_Valid2F  in  1 each  fetch slot valid; slot 1 is the older
- i_Instr1F, i_Instr2F  in  D_WIDTH each  fetched instructions
- i_PC1F, i_PC2F  in  D_WIDTH each  PCs of the fetched instructions
- o_Ready  out  1  queue can accept two entries this cycle
- i_Pop  in  2  entries consumed by decode this cycle (0, 1 or 2)
- o_Valid1D, o_Valid2D  out  1 each  head and head+1 entries valid
- o_Instr1D, o_Instr2D, o_PC1D, o_PC2D  out  D_WIDTH each  head and head+1 contents
- o_Count  out  3  occupancy, 0 to 4

Function
REQ-004 The queue SHALL be a 4-entry circular buffer with a 2-bit head pointer, a 2-bit tail pointer and a 3-bit count register.
REQ-005 o_Ready SHALL be (count <= 2), computed from the registered count only, with no dependence on i_Pop.
REQ-006 A push SHALL be accepted only when o_Ready=1; when o_Ready=0, fetch slots SHALL be ignored with no state change.
REQ-007 Accepted valid slots SHALL be written in order, slot 1 then slot 2.
REQ-008 If only i_Valid2F=1, slot 2 SHALL be written as a single entry at the tail.
REQ-009 The number of pushed entries SHALL equal i_Valid1F + i_Valid2F.
REQ-010 The effective pop SHALL be min(i_Pop, count).
REQ-011 i_Pop=3 SHALL be treated as 2.
REQ-012 Popping more than is valid SHALL never underflow count or move head past tail.
REQ-013 On a simultaneous push and pop: count_next = count - pop_eff + push_n, head += pop_eff, tail += push_n, all mod 4.
REQ-014 o_Valid1D SHALL be (count >= 1) and o_Valid2D SHALL be (count >= 2); the data outputs SHALL come from storage[head] and storage[head+1], from registers only.
REQ-015 Latency SHALL be one cycle: an entry pushed at edge N is visible at the outputs after edge N.
REQ-016 There SHALL be no combinational path from any input to any output.
REQ-017 When i_Flush=1, at the next edge count, head and tail SHALL become 0, and any same-cycle push and pop SHALL be ignored.
REQ-018 When i_Flush=1, storage contents need not be cleared.
REQ-019 Pointer wrap-around from 3 to 0 SHALL be seamless, with no lost or duplicated entries across the wrap.
REQ-020 When the queue is full (count=4), o_Ready SHALL be 0; a pop of 2 in that cycle SHALL make count 2 and o_Ready 1 on the next cycle.

Reset
REQ-021 When rst=1 at a rising edge, head, tail and count SHALL become 0 and all storage entries SHALL become 0.
REQ-022 After reset, o_Valid1D=0, o_Valid2D=0, o_Ready=1, o_Count=0, and all data outputs SHALL be 0.
REQ-023 rst SHALL take priority over i_Flush, push and pop.
REQ-024 Asserting rst mid-operation SHALL drop all queued entries.

Configuration
REQ-025 The feature SHALL be controlled by the macro FQ_PERF_EN.
REQ-026 With FQ_PERF_EN defined, the block SHALL add output o_StallCnt (16 bits): a saturating counter incremented each cycle that has (i_Valid1F or i_Valid2F) and o_Ready=0.
REQ-027 o_StallCnt SHALL be cleared by rst and SHALL NOT be cleared by i_Flush.
REQ-028 o_StallCnt SHALL hold at 16'hFFFF once it saturates.
REQ-029 With FQ_PERF_EN undefined, the o_StallCnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then push {PC=0x00, 0x04} with instructions {0xE3A01001, 0xE2811001} -> next cycle o_Count=2, o_Valid1D=o_Valid2D=1, o_PC1D=0x00, o_PC2D=0x04.
REQ-031 Fill to count=4 with i_Pop=0 -> o_Ready=0; a further push of PC 0x10/0x14 is dropped; then i_Pop=2 -> o_PC1D=0x08, count=2, o_Ready=1.
REQ-032 Starting at count=3, push 2 and pop 1 in the same cycle -> count rejected (o_Ready=0, count stays 2 after pop); starting at count=2, push 2 and pop 2 -> count=2, head advances by 2, new entries appear after the wrap in order.
REQ-033 At count=1, i_Pop=2 -> count=0, o_Valid1D=0, no underflow; an i_Valid2F-only push of PC 0x20 -> o_PC1D=0x20, count=1.
REQ-034 At count=3, assert i_Flush with a simultaneous push -> next cycle count=0, o_Valid1D=0, o_Ready=1; assert rst mid-stream -> all outputs 0.
REQ-035 With FQ_PERF_EN defined, hold the queue full and push for 5 cycles -> o_StallCnt=5; i_Flush leaves it at 5; rst sets it to 0.
